// File: rtl/lsu_sram_slave.sv
// LSU-facing AXI-lite-style SRAM slave: independent AR/R and AW/W/B FSMs, programmable latency.
// Define LSU_SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra latency cycles per transaction.
module lsu_sram_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH_W   = 16,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW = $clog2(MAXLAT + 4);
  localparam logic [32:0] LIMIT = 33'd1 << (DEPTH_W + 2);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wreq_t;

  logic [31:0] mem [2**DEPTH_W];

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && ({1'b0, a - ADDR_BASE} < LIMIT);
  endfunction

  function automatic logic [DEPTH_W-1:0] word_idx(input logic [31:0] a);
    return DEPTH_W'((a - ADDR_BASE) >> 2);
  endfunction

  logic [CW-1:0] extra;
`ifdef LSU_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk)
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign extra = CW'(lfsr[1:0]);
`else
  assign extra = '0;
`endif

  // read channel
  r_state_t      r_state, r_state_n;
  logic [CW-1:0] r_cnt, r_cnt_n;
  logic          r_sample;
  logic [31:0]   ar_addr;

  always_comb begin
    r_state_n = r_state;
    r_cnt_n   = r_cnt;
    r_sample  = 1'b0;
    case (r_state)
      R_IDLE: if (arvalid) begin
        r_state_n = R_WAIT;
        r_cnt_n   = CW'(READ_LAT - 1) + extra;
      end
      R_WAIT: if (r_cnt == '0) begin
        r_sample  = 1'b1;
        r_state_n = R_RESP;
      end else r_cnt_n = r_cnt - CW'(1);
      R_RESP: if (rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      ar_addr <= '0;
      rdata   <= '0;
      rresp   <= 1'b0;
    end else begin
      r_state <= r_state_n;
      r_cnt   <= r_cnt_n;
      if (arvalid && arready) ar_addr <= araddr;
      if (r_sample) begin
        rresp <= !in_range(ar_addr);
        rdata <= in_range(ar_addr) ? (mem[word_idx(ar_addr)] >> {ar_addr[1:0], 3'b000}) : '0;
      end
    end
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);

  // write channel: AW and W are latched independently, then the pair proceeds together
  w_state_t      w_state, w_state_n;
  logic [CW-1:0] w_cnt, w_cnt_n;
  logic          aw_have, w_have, aw_have_n, w_have_n, w_commit;
  wreq_t         wq;

  always_comb begin
    w_state_n = w_state;
    w_cnt_n   = w_cnt;
    aw_have_n = aw_have;
    w_have_n  = w_have;
    w_commit  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_have_n = aw_have | awvalid;
        w_have_n  = w_have | wvalid;
        if (aw_have_n && w_have_n) begin
          w_state_n = W_WAIT;
          w_cnt_n   = CW'(WRITE_LAT - 1) + extra;
        end
      end
      W_WAIT: if (w_cnt == '0) begin
        w_commit  = 1'b1;
        w_state_n = W_RESP;
      end else w_cnt_n = w_cnt - CW'(1);
      W_RESP: if (bready) begin
        w_state_n = W_IDLE;
        aw_have_n = 1'b0;
        w_have_n  = 1'b0;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_have <= 1'b0;
      w_have  <= 1'b0;
      wq      <= '0;
      bresp   <= 1'b0;
    end else begin
      w_state <= w_state_n;
      w_cnt   <= w_cnt_n;
      aw_have <= aw_have_n;
      w_have  <= w_have_n;
      if (awvalid && awready) wq.addr <= awaddr;
      if (wvalid && wready) begin
        wq.data <= wdata;
        wq.strb <= wstrb;
      end
      if (w_commit) bresp <= !in_range(wq.addr);
    end
  end

  assign awready = (w_state == W_IDLE) && !aw_have;
  assign wready  = (w_state == W_IDLE) && !w_have;
  assign bvalid  = (w_state == W_RESP);

  // lanes shifted past byte 3 fall off, so a sub-word write never spills into the next word
  logic [3:0]  wbe;
  logic [31:0] wword;
  assign wbe   = wq.strb << wq.addr[1:0];
  assign wword = wq.data << {wq.addr[1:0], 3'b000};

  always_ff @(posedge clk)
    if (!rst && w_commit && in_range(wq.addr))
      for (int l = 0; l < 4; l++)
        if (wbe[l]) mem[word_idx(wq.addr)][8*l +: 8] <= wword[8*l +: 8];
endmodule

// File: tb/tb_lsu_sram_slave.sv
// Scoreboard bench for lsu_sram_slave: byte-array reference model, directed cases, then random traffic.
module tb_lsu_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DW = 16, RL = 1, WL = 1;
`ifdef LSU_SRAM_RAND_DELAY_EN
  localparam int XMAX = 3;
`else
  localparam int XMAX = 0;
`endif
  localparam logic [31:0] SPAN = 32'd4 << DW;

  logic clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic arvalid, arready, rresp, rvalid, rready;
  logic awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [3:0] wstrb;

  lsu_sram_slave #(.ADDR_BASE(BASE), .DEPTH_W(DW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct packed { logic resp; logic [31:0] data; } rsp_t;
  rsp_t rq[$];
  logic bq[$];
  logic [7:0] mb [int unsigned];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // reference model: byte-addressed store, read returns the bytes from addr up to the word end
  function automatic logic inr(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic rsp_t ref_read(input logic [31:0] a);
    rsp_t r;
    int unsigned off;
    r.resp = !inr(a);
    r.data = '0;
    if (inr(a)) begin
      off = a - BASE;
      for (int k = 0; (off % 4) + k < 4; k++) r.data[8*k +: 8] = mb[off + k];
    end
    return r;
  endfunction

  function automatic logic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned off;
    if (!inr(a)) return 1'b1;
    off = a - BASE;
    for (int i = 0; i < 4; i++)
      if (s[i] && (off % 4) + i < 4) mb[off + i] = d[8*i +: 8];
    return 1'b0;
  endfunction

  function automatic int widx(input int k);
    return (k < 16) ? k : (2**DW) - 20 + k;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 85) return BASE + 4 * widx($urandom_range(0, 19)) + $urandom_range(0, 3);
    if (r < 92) return BASE - 1 - $urandom_range(0, 1000);
    return BASE + SPAN + $urandom_range(0, 4000);
  endfunction

  task automatic send_ar(input logic [31:0] a);
    bit hs = 0; int n = 0;
    #1 araddr = a; arvalid = 1'b1;
    while (!hs && n < 50) begin @(negedge clk); hs = arready; @(posedge clk); n++; end
    #1 arvalid = 1'b0;
    if (!hs) timeout("ar_handshake");
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit hs = 0; int n = 0;
    #1 awaddr = a; awvalid = 1'b1;
    while (!hs && n < 50) begin @(negedge clk); hs = awready; @(posedge clk); n++; end
    #1 awvalid = 1'b0;
    if (!hs) timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit hs = 0; int n = 0;
    #1 wdata = d; wstrb = s; wvalid = 1'b1;
    while (!hs && n < 50) begin @(negedge clk); hs = wready; @(posedge clk); n++; end
    #1 wvalid = 1'b0;
    if (!hs) timeout("w_handshake");
  endtask

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int skew);
    fork
      begin if (skew > 0) repeat (skew) @(posedge clk); send_aw(a); end
      begin if (skew < 0) repeat (-skew) @(posedge clk); send_w(d, s); end
    join
  endtask

  task automatic get_r(input int stall);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 60);
    if (!rvalid) begin timeout("rvalid"); return; end
    @(posedge clk);
    repeat (stall) @(posedge clk);
    #1 rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
  endtask

  task automatic get_b(input int stall);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 60);
    if (!bvalid) begin timeout("bvalid"); return; end
    @(posedge clk);
    repeat (stall) @(posedge clk);
    #1 bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
  endtask

  // monitor: handshake timestamps, latency, stall stability, scoreboard pops
  int ar_e, aw_e, w_e, lat, b_acc = 0;
  bit rv_q, rr_q, bv_q, br_q;
  rsp_t r_hold;
  logic b_hold;
  always @(negedge clk) begin
    if (rst) begin
      rv_q = 0; rr_q = 0; bv_q = 0; br_q = 0;
    end else begin
      if (arvalid && arready) ar_e = cyc + 1;
      if (awvalid && awready) aw_e = cyc + 1;
      if (wvalid && wready)   w_e  = cyc + 1;
      if (rvalid && !rv_q) begin
        lat = cyc - ar_e; checks++;
        if (lat < RL || lat > RL + XMAX) begin
          errors++; $display("FAIL r_latency: got %0d want %0d..%0d", lat, RL, RL + XMAX);
        end
        r_hold = {rresp, rdata};
      end else if (rvalid && !rr_q) chk("r_stable", {rresp, rdata}, r_hold);
      if (rvalid && rready) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else chk("r_resp_data", {rresp, rdata}, rq.pop_front());
      end
      if (bvalid && !bv_q) begin
        lat = cyc - ((aw_e > w_e) ? aw_e : w_e); checks++;
        if (lat < WL || lat > WL + XMAX) begin
          errors++; $display("FAIL b_latency: got %0d want %0d..%0d", lat, WL, WL + XMAX);
        end
        b_hold = bresp;
      end else if (bvalid && !br_q) chk("b_stable", bresp, b_hold);
      if (bvalid && bready) begin
        b_acc++;
        if (bq.size() == 0) timeout("b_unexpected");
        else chk("bresp", bresp, bq.pop_front());
      end
      rv_q = rvalid; rr_q = rready; bv_q = bvalid; br_q = bready;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, a2, d;
    logic [3:0] s;
    rsp_t lastv;
    int nb0, op;
    rst = 1; araddr = 0; arvalid = 0; rready = 0; awaddr = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 1); chk("rst_awready", awready, 1); chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);   chk("rst_bvalid", bvalid, 0);   chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);     chk("rst_bresp", bresp, 0);
    @(posedge clk); #1 rst = 0;

    // give every word the bench touches a known value
    for (int k = 0; k < 20; k++) begin
      a = BASE + 4 * widx(k); d = $urandom;
      bq.push_back(ref_write(a, d, 4'hF)); wr(a, d, 4'hF, 0); get_b(0);
    end

    // word round trip and byte alignment
    void'(ref_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF));
    bq.push_back(1'b0); wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0); get_b(0);
    rq.push_back({1'b0, 32'hDEAD_BEEF}); send_ar(32'h8000_0010); get_r(0);
    void'(ref_write(32'h8000_0013, 32'h0000_00AB, 4'h1));
    bq.push_back(1'b0); wr(32'h8000_0013, 32'h0000_00AB, 4'h1, 0); get_b(1);
    rq.push_back({1'b0, 32'hABAD_BEEF}); send_ar(32'h8000_0010); get_r(0);
    rq.push_back({1'b0, 32'h0000_00AB}); send_ar(32'h8000_0013); get_r(0);
    rq.push_back({1'b0, 32'h0000_ABAD}); send_ar(32'h8000_0012); get_r(0);

    // decode errors, last word untouched
    rq.push_back({1'b1, 32'h0}); send_ar(32'h7FFF_FFFC); get_r(0);
    lastv = ref_read(BASE + SPAN - 4);
    void'(ref_write(BASE + SPAN, 32'h5555_AAAA, 4'hF));
    bq.push_back(1'b1); wr(BASE + SPAN, 32'h5555_AAAA, 4'hF, 0); get_b(0);
    rq.push_back(lastv); send_ar(BASE + SPAN - 4); get_r(0);

    // W leads AW by 3 cycles
    void'(ref_write(32'h8000_0020, 32'h1357_9BDF, 4'hF));
    bq.push_back(1'b0); nb0 = b_acc;
    fork
      send_w(32'h1357_9BDF, 4'hF);
      begin repeat (3) @(posedge clk); send_aw(32'h8000_0020); end
      begin repeat (2) @(posedge clk); @(negedge clk); chk("wready_after_w", wready, 0); chk("bvalid_before_aw", bvalid, 0); end
    join
    get_b(0);
    repeat (3) @(posedge clk);
    chk("b_pulse_count", b_acc - nb0, 1);

    // rready held low for 5 cycles
    rq.push_back({1'b0, 32'h1357_9BDF}); send_ar(32'h8000_0020); get_r(5);

    // same-cycle read and write to one word
    void'(ref_write(32'h8000_0014, 32'h0123_4567, 4'hF));
    bq.push_back(1'b0); wr(32'h8000_0014, 32'h0123_4567, 4'hF, -2); get_b(0);
    rq.push_back({1'b0, 32'h0123_4567});
    void'(ref_write(32'h8000_0014, 32'hCAFE_F00D, 4'hF));
    bq.push_back(1'b0);
    fork send_ar(32'h8000_0014); wr(32'h8000_0014, 32'hCAFE_F00D, 4'hF, 0); join
    fork get_r(0); get_b(0); join
    rq.push_back({1'b0, 32'hCAFE_F00D}); send_ar(32'h8000_0014); get_r(0);

    // reset while both channels are waiting
    fork send_ar(32'h8000_0010); wr(32'h8000_0010, 32'h1122_3344, 4'hF, 0); join
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) begin
      @(negedge clk); chk("rst_abort_rvalid", rvalid, 0); chk("rst_abort_bvalid", bvalid, 0);
    end
    chk("rst_abort_arready", arready, 1); chk("rst_abort_awready", awready, 1); chk("rst_abort_wready", wready, 1);
    @(posedge clk);
    rq.push_back({1'b0, 32'hABAD_BEEF}); send_ar(32'h8000_0010); get_r(0);

    // random traffic against the model
    for (int it = 0; it < 1000; it++) begin
      a = rand_addr(); d = $urandom; s = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if (op < 4) begin
        rq.push_back(ref_read(a)); send_ar(a); get_r($urandom_range(0, 3));
      end else if (op < 8) begin
        bq.push_back(ref_write(a, d, s)); wr(a, d, s, $urandom_range(0, 6) - 3); get_b($urandom_range(0, 3));
      end else begin
        a2 = (op == 9) ? a : rand_addr();
        rq.push_back(ref_read(a));
        bq.push_back(ref_write(a2, d, s));
        fork send_ar(a); wr(a2, d, s, 0); join
        fork get_r($urandom_range(0, 3)); get_b($urandom_range(0, 3)); join
      end
    end

    repeat (5) @(posedge clk);
    chk("r_queue_empty", rq.size(), 0);
    chk("b_queue_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
